// File: rtl/rect_fill_engine.sv
// Rectangle fill engine for the 800x600x8bpp frame buffer.
// Emits one raster-ordered pixel write per clock between START and DONE.
module rect_fill_engine #(
  parameter int HSIZE = 800,
  parameter int VSIZE = 600
) (
  input  logic       PIXEL_CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [9:0] X0,
  input  logic [9:0] Y0,
  input  logic [9:0] X1,
  input  logic [9:0] Y1,
  input  logic [7:0] COLOR,
  output logic [9:0] PIX_HORIZONTAL,
  output logic [9:0] PIX_VERTICAL,
  output logic [7:0] PIX_COLOR,
  output logic       PIX_WE,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [9:0] XMAX = 10'(HSIZE - 1);
  localparam logic [9:0] YMAX = 10'(VSIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    LAST
  } state_t;

  state_t state_q, state_d;

  logic [9:0] xl_q, xr_q, yt_q, yb_q;
  logic [9:0] xl_d, xr_d, yt_d, yb_d;
  logic [9:0] x_d, y_d;
  logic [7:0] col_d;
  logic       we_d, busy_d, done_d;

  logic [9:0] lo_x, hi_x, lo_y, hi_y;
  logic [9:0] cl_xl, cl_xr, cl_yt, cl_yb;
  logic       at_end;

  // Order the corners first, then clamp into the visible area.
  always_comb begin
    lo_x  = (X0 < X1) ? X0 : X1;
    hi_x  = (X0 < X1) ? X1 : X0;
    lo_y  = (Y0 < Y1) ? Y0 : Y1;
    hi_y  = (Y0 < Y1) ? Y1 : Y0;
    cl_xl = (lo_x > XMAX) ? XMAX : lo_x;
    cl_xr = (hi_x > XMAX) ? XMAX : hi_x;
    cl_yt = (lo_y > YMAX) ? YMAX : lo_y;
    cl_yb = (hi_y > YMAX) ? YMAX : hi_y;
  end

  assign at_end = (PIX_HORIZONTAL == xr_q)
                && (PIX_VERTICAL == yb_q);

  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    yt_d    = yt_q;
    yb_d    = yb_q;
    x_d     = PIX_HORIZONTAL;
    y_d     = PIX_VERTICAL;
    col_d   = PIX_COLOR;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FILL;
          xl_d    = cl_xl;
          xr_d    = cl_xr;
          yt_d    = cl_yt;
          yb_d    = cl_yb;
          x_d     = cl_xl;
          y_d     = cl_yt;
          col_d   = COLOR;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      FILL: begin
        if (ABORT || at_end) begin
          state_d = LAST;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          if (PIX_HORIZONTAL < xr_q) begin
            x_d = PIX_HORIZONTAL + 10'd1;
          end else begin
            x_d = xl_q;
            y_d = PIX_VERTICAL + 10'd1;
          end
        end
      end
      LAST: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      xl_q           <= '0;
      xr_q           <= '0;
      yt_q           <= '0;
      yb_q           <= '0;
      PIX_HORIZONTAL <= '0;
      PIX_VERTICAL   <= '0;
      PIX_COLOR      <= '0;
      PIX_WE         <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
    end else begin
      state_q        <= state_d;
      xl_q           <= xl_d;
      xr_q           <= xr_d;
      yt_q           <= yt_d;
      yb_q           <= yb_d;
      PIX_HORIZONTAL <= x_d;
      PIX_VERTICAL   <= y_d;
      PIX_COLOR      <= col_d;
      PIX_WE         <= we_d;
      BUSY           <= busy_d;
      DONE           <= done_d;
    end
  end

endmodule
